// File: rtl/clkdiv_pkg.sv
// Shared constants for the programmable clock-enable divider.
// Imported by prog_clk_divider.
package clkdiv_pkg;

  localparam int CLKDIV_CNT_W_DEFAULT      = 16;
  localparam int CLKDIV_MIN_HALF           = 1;
  localparam int CLKDIV_RESET_HALF_DEFAULT = 10;

endpackage

// File: rtl/prog_clk_divider.sv
// Runtime-reprogrammable even-ratio clock-enable divider with edge strobes.
// Define PROG_CLKDIV_STATUS_EN to add the wrapping period_cnt status output.
module prog_clk_divider
  import clkdiv_pkg::*;
#(
  parameter int CNT_W      = CLKDIV_CNT_W_DEFAULT,
  parameter int RESET_HALF = CLKDIV_RESET_HALF_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [CNT_W-1:0] half_in,
  input  logic             load,
  output logic             busy,
  output logic             div_clk,
  output logic             rise_tick,
`ifdef PROG_CLKDIV_STATUS_EN
  output logic             fall_tick,
  output logic [CNT_W-1:0] period_cnt
`else
  output logic             fall_tick
`endif
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_H = CNT_W'(CLKDIV_MIN_HALF);
  localparam logic [CNT_W-1:0] RST_H = CNT_W'(RESET_HALF);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] h_act_q, h_act_d;
  logic [CNT_W-1:0] h_pend_q, h_pend_d;
  logic             pend_q, pend_d;
  logic             div_q, div_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             wrap;
  logic [CNT_W-1:0] half_cl;

  assign wrap    = (cnt_q == h_act_q - ONE);
  assign half_cl = (half_in < MIN_H) ? MIN_H : half_in;

  // Apply only at the 1->0 toggle so each period keeps a single H.
  always_comb begin
    cnt_d    = cnt_q;
    h_act_d  = h_act_q;
    h_pend_d = h_pend_q;
    pend_d   = pend_q;
    div_d    = div_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (en) begin
      if (wrap) begin
        cnt_d  = '0;
        div_d  = ~div_q;
        rise_d = ~div_q;
        fall_d = div_q;
        if (div_q && pend_q) begin
          h_act_d = h_pend_q;
          pend_d  = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
    if (load) begin
      h_pend_d = half_cl;
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      h_act_q  <= RST_H;
      h_pend_q <= '0;
      pend_q   <= 1'b0;
      div_q    <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      h_act_q  <= h_act_d;
      h_pend_q <= h_pend_d;
      pend_q   <= pend_d;
      div_q    <= div_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign busy      = pend_q;
  assign div_clk   = div_q;
  assign rise_tick = rise_q;
  assign fall_tick = fall_q;

`ifdef PROG_CLKDIV_STATUS_EN
  logic [CNT_W-1:0] period_q, period_d;

  assign period_d = fall_d ? period_q + ONE : period_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      period_q <= '0;
    end else begin
      period_q <= period_d;
    end
  end

  assign period_cnt = period_q;
`endif

endmodule
